piso_tx: RTL and testbench

- Parallel-in serial-out transmitter; the transmit end of the team's serial shift link.
- Accepts one WIDTH-bit word through a valid/ready load handshake, then drives it out one bit per clock on ser_out, with a ser_valid qualifier.
- Pulses done after the final bit.
- Feeds the team's serial-in shift-register receivers. It uses the same falling-edge clocking and asynchronous reset as those receivers.

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_bit_counter.sv | 50 +++++
 rtl/piso_tx.sv | 185 ++++++++++++++++++
 tb/tb_piso_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the piso_tx parallel-in serial-out transmitter.
//   state_e        : transmitter FSM states (IDLE, SHIFT, optional PARITY)
//   DEFAULT_WIDTH  : default number of data bits per word
//   countWidth()   : bit-counter width for a given word width (minimum 1)
// ---------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit word still needs a one-bit counter, so $clog2 is floored at 1.
    function automatic int countWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Up-counter that tracks which bit of the word is currently on the line.
// Updates on the falling edge of clk; asynchronous active-high reset.
// Ports:
//   clk        : clock, falling-edge active
//   reset      : asynchronous, active-high; clears the count
//   clear_i    : synchronous clear to 0 (has priority over enable_i)
//   enable_i   : increment by one
//   terminal_o : high while the count equals WIDTH-1
// ---------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int CW = countWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins so a new word always starts from bit 0.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, same falling-edge clocking as the rest of the link.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx
// Parallel-in serial-out transmitter for the serial shift link. Accepts one
// WIDTH-bit word via a valid/ready handshake, then drives it out one bit per
// clock period on ser_out, qualified by ser_valid, and pulses done for one
// period once the word has been sent. All state changes on the falling edge
// of clk; reset is asynchronous and active-high.
//
// Optional feature (macro PISO_TX_PARITY_EN): appends one even-parity bit
// after the data bits; done then follows the parity period.
//
// Ports:
//   clk        : clock, falling-edge active
//   reset      : asynchronous, active-high reset
//   load_valid : load_data holds a word to send
//   load_ready : transmitter is idle and will accept a word
//   load_data  : word to transmit
//   ser_out    : serial data bit (registered)
//   ser_valid  : ser_out carries a transmitted bit (registered)
//   busy       : a word is in flight
//   done       : one-period pulse after the final bit (registered)
// ---------------------------------------------------------------------------
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic             serOut_q, serOut_d;
    logic             serValid_q, serValid_d;
    logic             done_q, done_d;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             loadFire;
    logic             lastBit;
    logic             cntEnable;
    logic [WIDTH-1:0] srcWord;
    logic [WIDTH-1:0] nextRest;
    logic             nextBit;

    assign loadFire  = (state_q == ST_IDLE) && load_valid;
    assign cntEnable = (state_q == ST_SHIFT) && !lastBit;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (loadFire),
        .enable_i   (cntEnable),
        .terminal_o (lastBit)
    );

    // The outgoing bit comes straight from load_data on the handshake edge
    // (zero latency) and from the shift register afterwards, so one
    // extract-and-shift path serves both cases.
    always_comb begin
        srcWord = loadFire ? load_data : shiftReg_q;
        if (LSB_FIRST) begin
            nextBit  = srcWord[0];
            nextRest = srcWord >> 1;
        end else begin
            nextBit  = srcWord[WIDTH-1];
            nextRest = srcWord << 1;
        end
    end

    // State and output registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shiftReg_q <= '0;
            serOut_q   <= 1'b0;
            serValid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            serOut_q   <= serOut_d;
            serValid_q <= serValid_d;
            done_q     <= done_d;
`ifdef PISO_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (lastBit) begin
`ifdef PISO_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered-output next values; the line idles at 0 with ser_valid low.
    always_comb begin
        shiftReg_d = shiftReg_q;
        serOut_d   = 1'b0;
        serValid_d = 1'b0;
        done_d     = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shiftReg_d = nextRest;
                    serOut_d   = nextBit;
                    serValid_d = 1'b1;
`ifdef PISO_TX_PARITY_EN
                    parity_d   = ^load_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (!lastBit) begin
                    shiftReg_d = nextRest;
                    serOut_d   = nextBit;
                    serValid_d = 1'b1;
                end else begin
`ifdef PISO_TX_PARITY_EN
                    serOut_d   = parity_q;
                    serValid_d = 1'b1;
`else
                    done_d     = 1'b1;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                done_d = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign ser_out    = serOut_q;
    assign ser_valid  = serValid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx
// Self-checking bench for piso_tx. Two 8-bit instances (LSB-first and
// MSB-first) share the same load stimulus; a 1-bit instance covers the
// single-bit word. Expected serial streams are built from the loaded word by
// plain bit indexing. Honours PISO_TX_PARITY_EN when the design is built
// with it.
// ---------------------------------------------------------------------------
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadValid;
    logic [7:0] loadData;

    logic       readyL, serOutL, serValidL, busyL, doneL;
    logic       readyM, serOutM, serValidM, busyM, doneM;

    logic       loadValid1;
    logic [0:0] loadData1;
    logic       ready1, serOut1, serValid1, busy1, done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dutL (
        .clk        (clk),
        .reset      (reset),
        .load_valid (loadValid),
        .load_ready (readyL),
        .load_data  (loadData),
        .ser_out    (serOutL),
        .ser_valid  (serValidL),
        .busy       (busyL),
        .done       (doneL)
    );

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dutM (
        .clk        (clk),
        .reset      (reset),
        .load_valid (loadValid),
        .load_ready (readyM),
        .load_data  (loadData),
        .ser_out    (serOutM),
        .ser_valid  (serValidM),
        .busy       (busyM),
        .done       (doneM)
    );

    piso_tx #(.WIDTH(1), .LSB_FIRST(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (loadValid1),
        .load_ready (ready1),
        .load_data  (loadData1),
        .ser_out    (serOut1),
        .ser_valid  (serValid1),
        .busy       (busy1),
        .done       (done1)
    );

    // Inputs are driven and outputs sampled 1 time unit after the rising
    // edge, well away from the falling active edge.
    task automatic nextPeriod();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expL, input logic expM,
                               input logic expValid, input logic expBusy,
                               input logic expDone, input logic expReady);
        chk({tag, " L ser_out"},    serOutL,   expL);
        chk({tag, " L ser_valid"},  serValidL, expValid);
        chk({tag, " L busy"},       busyL,     expBusy);
        chk({tag, " L done"},       doneL,     expDone);
        chk({tag, " L load_ready"}, readyL,    expReady);
        chk({tag, " M ser_out"},    serOutM,   expM);
        chk({tag, " M ser_valid"},  serValidM, expValid);
        chk({tag, " M busy"},       busyM,     expBusy);
        chk({tag, " M done"},       doneM,     expDone);
        chk({tag, " M load_ready"}, readyM,    expReady);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Offers one word and checks the whole transmission through the done
    // period. Returns positioned in the done period. With keepValid set,
    // load_valid stays high throughout (with junk data while busy) and the
    // caller must offer the next word straight away.
    task automatic applyStimulus(input logic [7:0] data, input bit keepValid);
        logic qL[$];
        logic qM[$];
        for (int i = 0; i < 8; i++) begin
            qL.push_back(data[i]);
            qM.push_back(data[7-i]);
        end
`ifdef PISO_TX_PARITY_EN
        qL.push_back(^data);
        qM.push_back(^data);
`endif
        loadValid = 1'b1;
        loadData  = data;
        nextPeriod();
        loadValid = keepValid;
        loadData  = 8'($urandom);
        for (int k = 0; k < qL.size(); k++) begin
            checkOutput($sformatf("word %02h bit%0d", data, k),
                        qL[k], qM[k], 1'b1, 1'b1, 1'b0, 1'b0);
            nextPeriod();
            loadData = 8'($urandom);
        end
        checkOutput($sformatf("word %02h done", data),
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [7:0] w;
        int         gap;
        bit         hold;

        reset      = 1'b1;
        loadValid  = 1'b0;
        loadData   = 8'h00;
        loadValid1 = 1'b0;
        loadData1  = 1'b0;
        $display("[TB] start");

        // Reset held 3 periods, then idle values.
        nextPeriod();
        nextPeriod();
        nextPeriod();
        reset = 1'b0;
        checkIdle("after reset");
        nextPeriod();
        checkIdle("idle");

        // Single words: A5 (LSB view) and C3 (MSB view).
        applyStimulus(8'hA5, 1'b0);
        nextPeriod();
        checkIdle("after A5");
        applyStimulus(8'hC3, 1'b0);
        nextPeriod();
        checkIdle("after C3");

        // Back-to-back with load_valid held high.
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h00, 1'b0);
        nextPeriod();
        checkIdle("after b2b");

        // Reset in the middle of a word.
        loadValid = 1'b1;
        loadData  = 8'h0F;
        nextPeriod();
        loadValid = 1'b0;
        checkOutput("mid bit0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nextPeriod();
        checkOutput("mid bit1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nextPeriod();
        checkOutput("mid bit2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nextPeriod();
        reset     = 1'b1;
        loadValid = 1'b1;
        loadData  = 8'hFF;
        #1;
        chk("reset async L ser_valid", serValidL, 1'b0);
        chk("reset async L ser_out",   serOutL,   1'b0);
        chk("reset async L busy",      busyL,     1'b0);
        chk("reset async M ser_valid", serValidM, 1'b0);
        chk("reset async M busy",      busyM,     1'b0);
        nextPeriod();
        nextPeriod();
        chk("in reset L busy",      busyL,     1'b0);
        chk("in reset L ser_valid", serValidL, 1'b0);
        reset     = 1'b0;
        loadValid = 1'b0;
        nextPeriod();
        checkIdle("post reset 1");
        nextPeriod();
        checkIdle("post reset 2");
        applyStimulus(8'h81, 1'b0);
        nextPeriod();
        checkIdle("after 81");

        // Parity examples (plain data words when parity is not built in).
        applyStimulus(8'h07, 1'b0);
        nextPeriod();
        checkIdle("after 07");
        applyStimulus(8'h03, 1'b0);
        nextPeriod();
        checkIdle("after 03");

        // Randomized words, gaps and back-to-back runs.
        for (int n = 0; n < 8; n++) begin
            w    = 8'($urandom);
            hold = (n < 7) && ($urandom_range(0, 1) == 1);
            applyStimulus(w, hold);
            if (!hold) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g <= gap; g++) begin
                    nextPeriod();
                    checkIdle("random gap");
                end
            end
        end

        // One-bit word.
        loadValid1 = 1'b1;
        loadData1  = 1'b1;
        nextPeriod();
        loadValid1 = 1'b0;
        loadData1  = 1'b0;
        chk("w1 ser_out",    serOut1,   1'b1);
        chk("w1 ser_valid",  serValid1, 1'b1);
        chk("w1 busy",       busy1,     1'b1);
        chk("w1 load_ready", ready1,    1'b0);
        chk("w1 done early", done1,     1'b0);
        nextPeriod();
`ifdef PISO_TX_PARITY_EN
        chk("w1 parity ser_out",   serOut1,   1'b1);
        chk("w1 parity ser_valid", serValid1, 1'b1);
        chk("w1 parity done",      done1,     1'b0);
        nextPeriod();
`endif
        chk("w1 done",       done1,     1'b1);
        chk("w1 idle valid", serValid1, 1'b0);
        chk("w1 idle busy",  busy1,     1'b0);
        nextPeriod();
        chk("w1 done cleared", done1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
